// File: rtl/alu_iter.sv
// alu_iter: registered ALU with iterative RV32M multiply/divide/remainder.
//   Single-cycle ops (ADD..SRA, illegal) register res/flags on the accept edge
//   and pulse done during the following cycle. MUL*/DIV* run one bit per
//   cycle and pulse done WIDTH+1 cycles after accept (2 for divide specials).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   request handshake (in_ready = ~busy)
//   op, a, b         operation code and operands
//   busy             multi-cycle operation in progress
//   done             one-cycle pulse, res/flags valid
//   res, flags       result and {neg, zero, carry-out, overflow}, held
module alu_iter #(
   parameter int  WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic [3:0]       flags
);
   localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLT = 5'd2,  OP_SLTU = 5'd3;
   localparam logic [4:0] OP_AND = 5'd4,  OP_OR  = 5'd5,  OP_XOR = 5'd6,  OP_SLL  = 5'd7;
   localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13;
   localparam logic [4:0] OP_DIV = 5'd14, OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;
   localparam int M = WIDTH - 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

   state_t               state_q, state_d;
   logic [SHW-1:0]       cnt_q;
   logic [4:0]           op_q;
   logic [WIDTH-1:0]     a_q, opnd_q;
   logic [2*WIDTH-1:0]   acc_q;      // mul: {hi, lo} product; div: {rem, quo}
   logic                 qneg_q, rneg_q, divz_q, dovf_q;

   function automatic logic is_mul(input logic [4:0] o);
      return (o >= OP_MUL) && (o <= OP_MULHU);
   endfunction
   function automatic logic is_div(input logic [4:0] o);
      return (o >= OP_DIV) && (o <= OP_REMU);
   endfunction

   logic accept;
   assign busy     = (state_q != S_IDLE);
   assign in_ready = ~busy;
   assign accept   = in_valid & in_ready;

   // Single-cycle datapath
   logic             sub;
   logic [WIDTH-1:0] b_eff, sc_res;
   logic [WIDTH:0]   add_sum;
   logic             add_ov, sc_ov, sc_co;
   logic [SHW-1:0]   shamt;
   logic [3:0]       sc_flags;

   always_comb begin
      sub     = (op != OP_ADD);
      b_eff   = sub ? ~b : b;
      add_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      add_ov  = (a[M] == b_eff[M]) && (add_sum[M] != a[M]);
      shamt   = b[SHW-1:0];
      sc_res  = '1;
      sc_ov   = 1'b0;
      sc_co   = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin sc_res = add_sum[M:0]; sc_ov = add_ov; sc_co = add_sum[WIDTH]; end
         OP_SLT:  begin sc_res = {{M{1'b0}}, add_sum[M] ^ add_ov}; sc_co = add_sum[WIDTH]; end
         OP_SLTU: begin sc_res = {{M{1'b0}}, ~add_sum[WIDTH]};     sc_co = add_sum[WIDTH]; end
         OP_AND:  sc_res = a & b;
         OP_OR:   sc_res = a | b;
         OP_XOR:  sc_res = a ^ b;
         OP_SLL:  sc_res = a << shamt;
         OP_SRL:  sc_res = a >> shamt;
         OP_SRA:  sc_res = $signed(a) >>> shamt;
         default: sc_res = '1;   // illegal op: all ones, neg flag follows
      endcase
      sc_flags = {sc_res[M], sc_res == '0, sc_co, sc_ov};
   end

   // Operand conditioning at accept: magnitudes plus result signs
   logic             a_sgn, b_sgn;
   logic [WIDTH-1:0] mag_a, mag_b;

   always_comb begin
      a_sgn = a[M] & ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM));
      b_sgn = b[M] & ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
      mag_a = a_sgn ? -a : a;
      mag_b = b_sgn ? -b : b;
   end

   // Iteration steps
   logic [WIDTH:0]     mul_sum, div_sh;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] mul_next, div_next;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      // restoring divide: shift the next dividend bit into the partial remainder
      div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge   = div_sh >= {1'b0, opnd_q};
      div_diff = div_sh[WIDTH-1:0] - opnd_q;
      div_next = {div_ge ? div_diff : div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
   end

   // Final result selection
   logic [2*WIDTH-1:0] mul_full;
   logic [WIDTH-1:0]   quo, rmd, fin_res;
   logic [3:0]         fin_flags;

   always_comb begin
      mul_full = qneg_q ? -acc_q : acc_q;
      quo      = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rmd      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      if (is_mul(op_q))
         fin_res = (op_q == OP_MUL) ? mul_full[WIDTH-1:0] : mul_full[2*WIDTH-1:WIDTH];
      else if (divz_q)
         fin_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : a_q;
      else if (dovf_q)
         fin_res = (op_q == OP_DIV) ? a_q : '0;
      else
         fin_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo : rmd;
      fin_flags = {fin_res[M], fin_res == '0, 1'b0, dovf_q};
   end

   // FSM
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) begin
            if (is_mul(op))      state_d = S_MUL;
            else if (is_div(op)) state_d = S_DIV;
         end
         S_MUL: if (cnt_q == SHW'(WIDTH - 1)) state_d = S_FIN;
         // divide specials skip the iteration entirely
         S_DIV: if (divz_q || dovf_q || (cnt_q == SHW'(WIDTH - 1))) state_d = S_FIN;
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         done <= 1'b0; res <= '0; flags <= '0; cnt_q <= '0; op_q <= '0;
         a_q <= '0; opnd_q <= '0; acc_q <= '0;
         qneg_q <= 1'b0; rneg_q <= 1'b0; divz_q <= 1'b0; dovf_q <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: if (accept) begin
               op_q   <= op;
               a_q    <= a;
               cnt_q  <= '0;
               qneg_q <= (op == OP_MUL) ? 1'b0 : (a_sgn ^ b_sgn);
               rneg_q <= a_sgn;
               divz_q <= is_div(op) && (b == '0);
               dovf_q <= ((op == OP_DIV) || (op == OP_REM)) &&
                         (a == {1'b1, {M{1'b0}}}) && (b == '1);
               if (is_mul(op)) begin
                  acc_q  <= {{WIDTH{1'b0}}, mag_b};
                  opnd_q <= mag_a;
               end else if (is_div(op)) begin
                  acc_q  <= {{WIDTH{1'b0}}, mag_a};
                  opnd_q <= mag_b;
               end else begin
                  res   <= sc_res;
                  flags <= sc_flags;
                  done  <= 1'b1;
               end
            end
            S_MUL: begin acc_q <= mul_next; cnt_q <= cnt_q + SHW'(1); end
            S_DIV: begin acc_q <= div_next; cnt_q <= cnt_q + SHW'(1); end
            S_FIN: begin res <= fin_res; flags <= fin_flags; done <= 1'b1; end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed vector table for alu_iter (WIDTH=32) plus hand-written
// sequences for reset abort, back-to-back issue and the handshake (WIDTH=32/8).
module tb_alu_iter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, busy, done;
   logic [4:0]  op;
   logic [31:0] a, b, res;
   logic [3:0]  flags;

   logic        v8, rdy8, busy8, done8;
   logic [4:0]  op8;
   logic [7:0]  a8, b8, res8;
   logic [3:0]  flags8;

   alu_iter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .busy(busy), .done(done), .res(res), .flags(flags));

   alu_iter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .op(op8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .res(res8), .flags(flags8));

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a, b, res;
      logic [3:0]  flags;
      int          lat;
   } vec_t;

   vec_t vecs[$];
   int   n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic add_vec(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] r, input logic [3:0] f, input int l);
      vec_t v;
      v.op = o; v.a = va; v.b = vb; v.res = r; v.flags = f; v.lat = l;
      vecs.push_back(v);
   endtask

   // Issue one request at #1 after an edge; returns edges from accept to done.
   task automatic run32(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output int bad);
      op = o; a = va; b = vb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1; bad = 0;
      if (done) lat = 0;
      else for (int k = 1; k <= 100; k++) begin
         if (in_ready || !busy) bad++;
         @(posedge clk); #1;
         if (done) begin lat = k; break; end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bad, seen;

      // op, a, b, res, flags {neg,zero,co,ov}, latency
      add_vec(5'd0,  32'd3,        32'd4,        32'd7,        4'b0000, 0);
      add_vec(5'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b1001, 0);
      add_vec(5'd2,  32'hFFFFFFFF, 32'd1,        32'd1,        4'b0010, 0);
      add_vec(5'd3,  32'hFFFFFFFF, 32'd1,        32'd0,        4'b0110, 0);
      add_vec(5'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 0);
      add_vec(5'd5,  32'h0000000F, 32'h000000F0, 32'h000000FF, 4'b0000, 0);
      add_vec(5'd6,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'd0,        4'b0100, 0);
      add_vec(5'd7,  32'd1,        32'h0000001F, 32'h80000000, 4'b1000, 0);
      add_vec(5'd8,  32'h80000000, 32'd4,        32'h08000000, 4'b0000, 0);
      add_vec(5'd9,  32'h80000000, 32'h00000021, 32'hC0000000, 4'b1000, 0);
      add_vec(5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        4'b0000, 33);
      add_vec(5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        4'b0100, 33);
      add_vec(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, 33);
      add_vec(5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 33);
      add_vec(5'd10, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 4'b1000, 33);
      add_vec(5'd11, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 4'b1000, 33);
      add_vec(5'd14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b1000, 33);
      add_vec(5'd16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b1000, 33);
      add_vec(5'd15, 32'd100,      32'd7,        32'd14,       4'b0000, 33);
      add_vec(5'd17, 32'd100,      32'd7,        32'd2,        4'b0000, 33);
      add_vec(5'd14, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 4'b1000, 33);
      add_vec(5'd16, 32'd7,        32'hFFFFFFFE, 32'd1,        4'b0000, 33);
      add_vec(5'd15, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 4'b1000, 33);
      add_vec(5'd14, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b1000, 2);
      add_vec(5'd16, 32'd5,        32'd0,        32'd5,        4'b0000, 2);
      add_vec(5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1001, 2);
      add_vec(5'd31, 32'd1,        32'd2,        32'hFFFFFFFF, 4'b1000, 0);

      rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
      v8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_res", res, 0);
      chk("reset_flags", flags, 0);
      chk("reset_ready", in_ready, 1);
      chk("reset_res8", res8, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         run32(vecs[i].op, vecs[i].a, vecs[i].b, lat, bad);
         chk($sformatf("v%0d_res", i), res, vecs[i].res);
         chk($sformatf("v%0d_flags", i), flags, vecs[i].flags);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_busy", i), bad, 0);
         chk($sformatf("v%0d_ready_at_done", i), in_ready, 1);
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_pulse", i), done, 0);
      end

      // Reset during a DIVU: aborted, no done, outputs back to reset values
      op = 5'd15; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = 0;
      repeat (4) begin @(posedge clk); #1; if (done) seen++; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_res", res, 0);
      chk("rst_mid_flags", flags, 0);
      repeat (40) begin if (done) seen++; @(posedge clk); #1; end
      chk("rst_mid_no_done", seen, 0);
      run32(5'd0, 32'd3, 32'd4, lat, bad);
      chk("rst_add_res", res, 7);
      chk("rst_add_latency", lat, 0);

      // Back-to-back single-cycle ops
      @(posedge clk); #1;
      op = 5'd0; a = 32'hFFFFFFFF; b = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_done1", done, 1);
      chk("b2b_res1", res, 0);
      chk("b2b_flags1", flags, 4'b0110);
      chk("b2b_ready", in_ready, 1);
      op = 5'd1; a = 32'h80000000; b = 32'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_done2", done, 1);
      chk("b2b_res2", res, 32'h7FFFFFFF);
      chk("b2b_flags2", flags, 4'b0011);
      @(posedge clk); #1;
      chk("b2b_done_end", done, 0);

      // Handshake: in_valid held high with changing requests during a MUL
      op = 5'd10; a = 32'd3; b = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      lat = -1; bad = 0;
      for (int k = 1; k <= 100; k++) begin
         op = (k % 2 == 1) ? 5'd0 : 5'd13; a = k; b = k * 3;
         @(posedge clk); #1;
         if (done) begin lat = k; break; end
         if (in_ready) bad++;
      end
      chk("hs_latency", lat, 33);
      chk("hs_res", res, 15);
      chk("hs_ready_low", bad, 0);
      op = 5'd0; a = 32'd100; b = 32'd23;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hs_next_done", done, 1);
      chk("hs_next_res", res, 123);

      // Same handshake at WIDTH=8
      op8 = 5'd10; a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
      @(posedge clk); #1;
      lat = -1; bad = 0;
      for (int k = 1; k <= 100; k++) begin
         op8 = (k % 2 == 1) ? 5'd0 : 5'd15; a8 = 8'(k); b8 = 8'(k + 1);
         @(posedge clk); #1;
         if (done8) begin lat = k; break; end
         if (rdy8) bad++;
      end
      chk("w8_mul_latency", lat, 9);
      chk("w8_mul_res", res8, 8'h01);
      chk("w8_mul_flags", flags8, 4'b0000);
      chk("w8_ready_low", bad, 0);
      op8 = 5'd0; a8 = 8'h10; b8 = 8'h20;
      @(posedge clk); #1;
      chk("w8_next_done", done8, 1);
      chk("w8_next_res", res8, 8'h30);
      op8 = 5'd13; a8 = 8'hFF; b8 = 8'hFF;
      @(posedge clk); #1;
      v8 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (done8) begin lat = k; break; end
      end
      chk("w8_mulhu_latency", lat, 9);
      chk("w8_mulhu_res", res8, 8'hFE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
